// File: rtl/writeback_unit_pkg.sv
// Shared types for the LC-3b write-back stage: NZP code type, its reset value and the source-select enum.
package lc3b_types;

  typedef logic [2:0] lc3b_nzp;

  localparam lc3b_nzp NZP_RESET = 3'b010;

  typedef enum logic [1:0] {
    WB_MEM_ADDR = 2'd0,
    WB_MEM_DATA = 2'd1,
    WB_NEW_PC   = 2'd2,
    WB_ALU      = 2'd3
  } wb_src_e;

  // A single source still needs a one-bit select so the port never collapses to zero width.
  function automatic int sel_width(input int n);
    if (n > 32'sd1) begin
      return $clog2(n);
    end else begin
      return 32'sd1;
    end
  endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Upstream instruction handshake and register-file write port of the write-back stage.
interface writeback_unit_if #(
  parameter int WIDTH      = 16,
  parameter int NUM_SRC    = 4,
  parameter int REG_ADDR_W = 3
);
  import lc3b_types::*;

  localparam int SEL_W = sel_width(NUM_SRC);

  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_SRC*WIDTH-1:0] in_src;
  logic [SEL_W-1:0]         in_sel;
  logic [REG_ADDR_W-1:0]    in_dest;
  logic                     in_ld_reg;
  logic                     in_ld_cc;
  logic                     rf_we;
  logic [REG_ADDR_W-1:0]    rf_dest;
  logic [WIDTH-1:0]         rf_data;

  modport master (
    output in_valid, in_src, in_sel, in_dest, in_ld_reg, in_ld_cc,
    input  in_ready, rf_we, rf_dest, rf_data
  );

  modport slave (
    input  in_valid, in_src, in_sel, in_dest, in_ld_reg, in_ld_cc,
    output in_ready, rf_we, rf_dest, rf_data
  );

endinterface

// File: rtl/writeback_unit_gencc.sv
// wb_gencc: combinational NZP generation from a write-back result (exactly one bit set).
module wb_gencc
  import lc3b_types::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] value,
  output lc3b_nzp          nzp
);

  logic n_s;
  logic z_s;

  // Sign bit, zero test, and positive as the remaining case.
  always_comb begin
    n_s = value[WIDTH-1];
    z_s = (value == {WIDTH{1'b0}});
    nzp = {n_s, z_s, (!n_s) && (!z_s)};
  end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: final pipeline stage with registered instruction, result mux, NZP register and retire counter.
// Defining WB_FORWARD_EN adds a registered forwarding copy of the last completed register write.
module writeback_unit
  import lc3b_types::*;
#(
  parameter int WIDTH      = 16,
  parameter int NUM_SRC    = 4,
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  writeback_unit_if.slave       wb,
  input  logic                  hold,
  input  logic                  flush,
  output lc3b_nzp               cc_out,
  output logic [CNT_W-1:0]      retire_count
`ifdef WB_FORWARD_EN
  ,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_dest,
  output logic [WIDTH-1:0]      fwd_data
`endif
);

  localparam int SEL_W = sel_width(NUM_SRC);

  logic                     valid_r;
  logic [NUM_SRC*WIDTH-1:0] src_r;
  logic [SEL_W-1:0]         sel_r;
  logic [REG_ADDR_W-1:0]    dest_r;
  logic                     ld_reg_r;
  logic                     ld_cc_r;
  lc3b_nzp                  cc_r;
  logic [CNT_W-1:0]         count_r;

  logic                     ready_s;
  logic                     capture_s;
  logic                     fire_s;
  logic                     rf_we_s;
  logic [WIDTH-1:0]         result_s;
  lc3b_nzp                  gencc_s;

  // Handshake decode and result selection from the registered copy; out-of-range selects read as zero.
  always_comb begin
    ready_s   = (!valid_r) || (!hold);
    capture_s = wb.in_valid && ready_s && (!flush);
    fire_s    = valid_r && (!hold) && (!flush);
    rf_we_s   = fire_s && ld_reg_r;
    result_s  = {WIDTH{1'b0}};
    if (int'(sel_r) < NUM_SRC) begin
      result_s = src_r[int'(sel_r)*WIDTH +: WIDTH];
    end else begin
      result_s = {WIDTH{1'b0}};
    end
  end

  wb_gencc #(.WIDTH(WIDTH)) u_gencc (
    .value (result_s),
    .nzp   (gencc_s)
  );

  assign wb.in_ready  = ready_s;
  assign wb.rf_we     = rf_we_s;
  assign wb.rf_dest   = dest_r;
  assign wb.rf_data   = result_s;
  assign cc_out       = cc_r;
  assign retire_count = count_r;

  // Stage register: capture may coincide with fire, giving one instruction per cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_r  <= 1'b0;
      src_r    <= {(NUM_SRC*WIDTH){1'b0}};
      sel_r    <= {SEL_W{1'b0}};
      dest_r   <= {REG_ADDR_W{1'b0}};
      ld_reg_r <= 1'b0;
      ld_cc_r  <= 1'b0;
    end else if (flush) begin
      valid_r  <= 1'b0;
    end else if (capture_s) begin
      valid_r  <= 1'b1;
      src_r    <= wb.in_src;
      sel_r    <= wb.in_sel;
      dest_r   <= wb.in_dest;
      ld_reg_r <= wb.in_ld_reg;
      ld_cc_r  <= wb.in_ld_cc;
    end else if (fire_s) begin
      valid_r  <= 1'b0;
    end else begin
      valid_r  <= valid_r;
    end
  end

  // Architectural NZP and retire counter advance only when an instruction actually retires.
  always_ff @(posedge clock) begin
    if (reset) begin
      cc_r    <= NZP_RESET;
      count_r <= {CNT_W{1'b0}};
    end else if (fire_s) begin
      cc_r    <= ld_cc_r ? gencc_s : cc_r;
      count_r <= count_r + CNT_W'(1'b1);
    end else begin
      cc_r    <= cc_r;
      count_r <= count_r;
    end
  end

`ifdef WB_FORWARD_EN
  // Forwarding copy of the most recent completed write for the decode stage.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      fwd_valid <= 1'b0;
      fwd_dest  <= {REG_ADDR_W{1'b0}};
      fwd_data  <= {WIDTH{1'b0}};
    end else if (rf_we_s) begin
      fwd_valid <= 1'b1;
      fwd_dest  <= dest_r;
      fwd_data  <= result_s;
    end else begin
      fwd_valid <= fwd_valid;
      fwd_dest  <= fwd_dest;
      fwd_data  <= fwd_data;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: spec-level model compared every cycle plus directed literal checks.
module tb_writeback_unit;
  import lc3b_types::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        hold;
  logic        flush;
  lc3b_nzp     cc_m;
  logic [31:0] cnt_m;
  lc3b_nzp     cc_c;
  logic [3:0]  cnt_c;
`ifdef WB_FORWARD_EN
  logic        fv_m, fv_c;
  logic [2:0]  fd_m, fd_c;
  logic [15:0] fdat_m, fdat_c;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  writeback_unit_if #(.WIDTH(16), .NUM_SRC(4), .REG_ADDR_W(3)) wb_m ();
  writeback_unit_if #(.WIDTH(16), .NUM_SRC(3), .REG_ADDR_W(3)) wb_c ();

  writeback_unit #(.WIDTH(16), .NUM_SRC(4), .REG_ADDR_W(3), .CNT_W(32)) dut_main (
    .clock(clock), .reset(reset), .wb(wb_m), .hold(hold), .flush(flush),
    .cc_out(cc_m), .retire_count(cnt_m)
`ifdef WB_FORWARD_EN
    , .fwd_valid(fv_m), .fwd_dest(fd_m), .fwd_data(fdat_m)
`endif
  );

  writeback_unit #(.WIDTH(16), .NUM_SRC(3), .REG_ADDR_W(3), .CNT_W(4)) dut_corner (
    .clock(clock), .reset(reset), .wb(wb_c), .hold(hold), .flush(flush),
    .cc_out(cc_c), .retire_count(cnt_c)
`ifdef WB_FORWARD_EN
    , .fwd_valid(fv_c), .fwd_dest(fd_c), .fwd_data(fdat_c)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] cc_of(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    else if (v == 16'h0000) return 3'b010;
    else return 3'b001;
  endfunction

  // ---------------- behavioural model of the main instance ----------------
  bit          m_live = 1'b0;
  bit          m_valid;
  logic [15:0] m_srcs [4];
  int          m_sel;
  logic [2:0]  m_dest;
  bit          m_ld_reg, m_ld_cc;
  logic [2:0]  m_cc;
  logic [31:0] m_cnt;

  wire         m_fire   = m_valid && !hold && !flush;
  wire         m_accept = wb_m.in_valid && (!m_valid || !hold) && !flush;
  wire [15:0]  m_result = m_srcs[m_sel];

  always @(posedge clock) begin
    if (reset) begin
      m_live  <= 1'b1;
      m_valid <= 1'b0;
      m_cc    <= 3'b010;
      m_cnt   <= 32'd0;
    end else begin
      if (m_fire) begin
        m_cnt <= m_cnt + 32'd1;
        if (m_ld_cc) m_cc <= cc_of(m_result);
      end
      if (flush) m_valid <= 1'b0;
      else if (m_accept) begin
        m_valid  <= 1'b1;
        for (int k = 0; k < 4; k++) m_srcs[k] <= wb_m.in_src[k*16 +: 16];
        m_sel    <= int'(wb_m.in_sel);
        m_dest   <= wb_m.in_dest;
        m_ld_reg <= wb_m.in_ld_reg;
        m_ld_cc  <= wb_m.in_ld_cc;
      end else if (m_fire) m_valid <= 1'b0;
    end
  end

  always @(negedge clock) begin
    if (m_live && !reset) begin
      check("model_in_ready", wb_m.in_ready, !m_valid || !hold);
      check("model_rf_we", wb_m.rf_we, m_fire && m_ld_reg);
      check("model_cc", cc_m, m_cc);
      check("model_count", cnt_m, m_cnt);
      if (m_valid) begin
        check("model_rf_dest", wb_m.rf_dest, m_dest);
        check("model_rf_data", wb_m.rf_data, m_result);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_m(input logic [15:0] alu, input logic [1:0] sel, input logic [2:0] dest,
                         input logic ld_reg, input logic ld_cc);
    wb_m.in_valid  = 1'b1;
    wb_m.in_src    = {alu, 16'h1111, 16'h2222, 16'h3333};
    wb_m.in_sel    = sel;
    wb_m.in_dest   = dest;
    wb_m.in_ld_reg = ld_reg;
    wb_m.in_ld_cc  = ld_cc;
  endtask

  logic [15:0] vals [4];
  logic [2:0]  ccs  [4];

  initial begin
    vals = '{16'h0000, 16'h0001, 16'hFFFF, 16'h7FFF};
    ccs  = '{3'b010, 3'b001, 3'b100, 3'b001};
    reset = 1'b1; hold = 1'b0; flush = 1'b0;
    drive_m(16'h0000, 2'd0, 3'd0, 1'b0, 1'b0);
    wb_m.in_valid = 1'b0;
    wb_c.in_valid = 1'b0; wb_c.in_src = 48'h0; wb_c.in_sel = 2'd0;
    wb_c.in_dest = 3'd0; wb_c.in_ld_reg = 1'b0; wb_c.in_ld_cc = 1'b0;

    // 1. reset
    tick(); tick();
    check("reset_rf_we", wb_m.rf_we, 1'b0);
    check("reset_cc", cc_m, 3'b010);
    check("reset_count", cnt_m, 32'd0);
    check("reset_in_ready", wb_m.in_ready, 1'b1);
    reset = 1'b0;

    // 2. single write
    drive_m(16'h8001, WB_ALU, 3'd5, 1'b1, 1'b1);
    tick();
    wb_m.in_valid = 1'b0;
    @(negedge clock);
    check("single_rf_we", wb_m.rf_we, 1'b1);
    check("single_rf_dest", wb_m.rf_dest, 3'd5);
    check("single_rf_data", wb_m.rf_data, 16'h8001);
    tick();
    check("single_cc", cc_m, 3'b100);
    check("single_count", cnt_m, 32'd1);

    // 3. stream of four back-to-back instructions
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_m(vals[i], WB_ALU, 3'(i), 1'b1, 1'b1);
      tick();
      if (i > 0) check("stream_cc", cc_m, ccs[i-1]);
      @(negedge clock);
      check("stream_rf_we", wb_m.rf_we, 1'b1);
      check("stream_rf_data", wb_m.rf_data, vals[i]);
    end
    wb_m.in_valid = 1'b0;
    tick();
    check("stream_cc_last", cc_m, 3'b001);
    check("stream_count", cnt_m, 32'd4);

    // 4. hold for three cycles with the stage full and a new instruction offered
    drive_m(16'h0042, WB_ALU, 3'd3, 1'b1, 1'b1);
    tick();
    drive_m(16'h1234, WB_ALU, 3'd6, 1'b1, 1'b0);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("hold_in_ready", wb_m.in_ready, 1'b0);
      check("hold_rf_we", wb_m.rf_we, 1'b0);
      check("hold_rf_data", wb_m.rf_data, 16'h0042);
      check("hold_count", cnt_m, 32'd4);
      tick();
    end
    hold = 1'b0;
    @(negedge clock);
    check("hold_release_we", wb_m.rf_we, 1'b1);
    check("hold_release_dest", wb_m.rf_dest, 3'd3);
    tick();
    wb_m.in_valid = 1'b0;
    check("hold_cc", cc_m, 3'b001);
    check("hold_count_after", cnt_m, 32'd5);
    @(negedge clock);
    check("b2b_rf_data", wb_m.rf_data, 16'h1234);
    tick();
    check("b2b_count", cnt_m, 32'd6);
    check("b2b_cc_kept", cc_m, 3'b001);

    // 5. flush with a held instruction plus a new one offered
    drive_m(16'h8000, WB_ALU, 3'd7, 1'b1, 1'b1);
    tick();
    drive_m(16'h0005, WB_ALU, 3'd2, 1'b1, 1'b1);
    hold = 1'b1;
    tick();
    flush = 1'b1;
    @(negedge clock);
    check("flush_rf_we", wb_m.rf_we, 1'b0);
    tick();
    flush = 1'b0; hold = 1'b0; wb_m.in_valid = 1'b0;
    check("flush_cc", cc_m, 3'b001);
    check("flush_count", cnt_m, 32'd6);
    @(negedge clock);
    check("flush_empty_we", wb_m.rf_we, 1'b0);
    check("flush_empty_ready", wb_m.in_ready, 1'b1);
    tick();
    check("flush_count_after", cnt_m, 32'd6);

    // 6. corner instance: out-of-range select and 4-bit counter wrap
    reset = 1'b1; tick(); reset = 1'b0;
    wb_c.in_valid = 1'b1; wb_c.in_src = {16'h0001, 16'h0002, 16'h8000};
    wb_c.in_sel = 2'd0; wb_c.in_dest = 3'd1; wb_c.in_ld_reg = 1'b1; wb_c.in_ld_cc = 1'b1;
    tick();
    wb_c.in_sel = 2'd3;
    tick();
    wb_c.in_valid = 1'b0;
    check("corner_cc_neg", cc_c, 3'b100);
    @(negedge clock);
    check("corner_sel3_we", wb_c.rf_we, 1'b1);
    check("corner_sel3_data", wb_c.rf_data, 16'h0000);
    tick();
    check("corner_sel3_cc", cc_c, 3'b010);
    check("corner_count2", cnt_c, 4'd2);
    wb_c.in_valid = 1'b1; wb_c.in_sel = 2'd1; wb_c.in_ld_cc = 1'b0;
    for (int i = 0; i < 13; i++) tick();
    wb_c.in_valid = 1'b0;
    tick();
    check("corner_count15", cnt_c, 4'd15);
    wb_c.in_valid = 1'b1;
    tick();
    wb_c.in_valid = 1'b0;
    tick();
    check("corner_wrap", cnt_c, 4'd0);
    check("corner_cc_kept", cc_c, 3'b010);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
